// File: rtl/seq_det_1011_pkg.sv
// Shared types and constants for the 1011 sequence detector and its counter.
package seq_det_1011_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  // Pattern bits, MSB is the first bit received.
  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_det_1011_sat_counter.sv
// Saturating up-counter with a sticky overflow flag and synchronous clear.
module sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Clr,
  input  logic             Inc,
  output logic [CNT_W-1:0] Count,
  output logic             Overflow
);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Count    <= '0;
      Overflow <= 1'b0;
    end else if (Clr) begin
      Count    <= '0;
      Overflow <= 1'b0;
    end else if (Inc) begin
      if (Count == '1) Overflow <= 1'b1;
      else             Count    <= Count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_1011.sv
// Overlapping Moore detector for 1-0-1-1 on a gated serial stream, with a
// saturating detection counter.
module seq_det_1011
  import seq_det_1011_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Din,
  input  logic             En,
  input  logic             Clr,
  output logic             Detect,
  output logic [CNT_W-1:0] Count,
  output logic             Overflow
);

  state_t state, next;
  logic   inc;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S0;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S0: if (En) next = (Din == PATTERN[3]) ? S1 : S0;
      S1: if (En) next = (Din == PATTERN[2]) ? S2 : S1;
      S2: if (En) next = (Din == PATTERN[1]) ? S3 : S0;
      S3: if (En) next = (Din == PATTERN[0]) ? S4 : S2;
      S4: if (En) next = Din ? S1 : S2;
      // Illegal codes recover even while sampling is disabled.
      default: next = S0;
    endcase
  end

  // S4 cannot re-enter itself, so En plus next==S4 marks a fresh entry.
  assign inc    = En && (next == S4);
  assign Detect = (state == S4);

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .Clock    (Clock),
    .Reset    (Reset),
    .Clr      (Clr),
    .Inc      (inc),
    .Count    (Count),
    .Overflow (Overflow)
  );

endmodule

// File: tb/tb_seq_det_1011.sv
// Directed bench for seq_det_1011: a CNT_W=4 and a CNT_W=2 instance share stimulus.
module tb_seq_det_1011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       det4, det2, ovf4, ovf2;
  logic [3:0] cnt4;
  logic [1:0] cnt2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #20 clk = ~clk;

  seq_det_1011 #(.CNT_W(4)) u_dut4 (
    .Clock(clk), .Reset(rst_n), .Din(din), .En(en), .Clr(clr),
    .Detect(det4), .Count(cnt4), .Overflow(ovf4)
  );

  seq_det_1011 #(.CNT_W(2)) u_dut2 (
    .Clock(clk), .Reset(rst_n), .Din(din), .En(en), .Clr(clr),
    .Detect(det2), .Count(cnt2), .Overflow(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, return just after the next rising edge.
  task automatic step(input logic d, input logic e, input logic c);
    @(negedge clk);
    din = d; en = e; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #5;
    rst_n = 1'b1;
  endtask

  // Feed bits with En=1, Clr=0.
  task automatic feed(input logic [15:0] bits, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(bits[n-1-i], 1'b1, 1'b0);
  endtask

  initial begin
    // Reset held across two edges with Din toggling
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    check("rst_det", {31'd0, det4}, 0);
    check("rst_cnt", {28'd0, cnt4}, 0);
    check("rst_ovf", {31'd0, ovf4}, 0);
    step(1'b0, 1'b1, 1'b0);
    check("rst_det2", {31'd0, det4}, 0);
    check("rst_cnt2", {28'd0, cnt4}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic detection 1,0,1,1 then 0 -> S2 (proved by 1,1 detecting)
    feed(16'b101, 3);
    check("basic_pre", {31'd0, det4}, 0);
    feed(16'b1, 1);
    check("basic_det", {31'd0, det4}, 1);
    check("basic_cnt", {28'd0, cnt4}, 1);
    feed(16'b0, 1);
    check("basic_fall", {31'd0, det4}, 0);
    feed(16'b11, 2);
    check("basic_s2", {31'd0, det4}, 1);
    check("basic_cnt2", {28'd0, cnt4}, 2);

    // Overlap 1011011 then 1111
    do_reset();
    feed(16'b1011, 4);
    check("ovl_det4", {31'd0, det4}, 1);
    feed(16'b01, 2);
    check("ovl_mid", {31'd0, det4}, 0);
    feed(16'b1, 1);
    check("ovl_det7", {31'd0, det4}, 1);
    check("ovl_cnt", {28'd0, cnt4}, 2);
    feed(16'b1111, 4);
    check("ovl_ones_det", {31'd0, det4}, 0);
    check("ovl_ones_cnt", {28'd0, cnt4}, 2);

    // Enable hold in S3, then Detect held while En=0
    do_reset();
    feed(16'b101, 3);
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    check("hold_det", {31'd0, det4}, 0);
    check("hold_cnt", {28'd0, cnt4}, 0);
    feed(16'b1, 1);
    check("hold_resume_det", {31'd0, det4}, 1);
    check("hold_resume_cnt", {28'd0, cnt4}, 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("hold_det_stay", {31'd0, det4}, 1);
    check("hold_cnt_stay", {28'd0, cnt4}, 1);

    // Saturation on the 2-bit instance
    do_reset();
    feed(16'b1011, 4);
    check("sat_c1", {30'd0, cnt2}, 1);
    feed(16'b011, 3);
    feed(16'b011, 3);
    check("sat_c3", {30'd0, cnt2}, 3);
    check("sat_c3_ovf", {31'd0, ovf2}, 0);
    feed(16'b011, 3);
    check("sat_c4", {30'd0, cnt2}, 3);
    check("sat_c4_ovf", {31'd0, ovf2}, 1);
    check("sat_c4_w4", {28'd0, cnt4}, 4);
    feed(16'b011, 3);
    check("sat_c5", {30'd0, cnt2}, 3);
    check("sat_c5_ovf", {31'd0, ovf2}, 1);
    check("sat_c5_w4", {28'd0, cnt4}, 5);
    feed(16'b01, 2);
    step(1'b1, 1'b1, 1'b1);
    check("clr_cnt", {30'd0, cnt2}, 0);
    check("clr_ovf", {31'd0, ovf2}, 0);
    check("clr_det", {31'd0, det2}, 1);
    check("clr_cnt_w4", {28'd0, cnt4}, 0);
    feed(16'b011, 3);
    check("post_clr_cnt", {30'd0, cnt2}, 1);
    step(1'b0, 1'b0, 1'b1);
    check("clr_no_en", {30'd0, cnt2}, 0);
    check("clr_no_en_det", {31'd0, det2}, 1);

    // Async reset between edges
    do_reset();
    feed(16'b1011, 4);
    check("ar_pre_det", {31'd0, det4}, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("ar_det", {31'd0, det4}, 0);
    check("ar_cnt", {28'd0, cnt4}, 0);
    #3;
    rst_n = 1'b1;
    feed(16'b101, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #5;
    rst_n = 1'b1;
    feed(16'b1, 1);
    check("ar_s1_det", {31'd0, det4}, 0);
    feed(16'b011, 3);
    check("ar_s1_proof", {31'd0, det4}, 1);
    check("ar_s1_cnt", {28'd0, cnt4}, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
